// File: rtl/addrdecode_skid.sv
// -----------------------------------------------------------------------------
// addrdecode_skid
//
// Registered address decoder for the crossbar request path. It accepts a
// request (address + payload) and picks one of NS slaves. On overlapping
// regions the lowest slave index wins, and each slave has a run-time enable.
// One cycle later the request is presented with a one-hot decode. Unmapped or
// disabled targets decode to the bus-error bit NS.
//
// A one-entry skid register sits in front of the output register. Because of
// it, o_stall is a flop output, and no combinational path runs from i_stall to
// o_stall.
//
// Ports
//   i_clk      rising-edge clock
//   i_reset    synchronous, active-high reset
//   i_valid    upstream request valid (ignored while o_stall is high)
//   o_stall    upstream stall, registered (high while the skid entry is full)
//   i_addr     request address
//   i_data     request payload, passed through untouched
//   i_enable   per-slave enable, sampled when the output register loads
//   o_valid    downstream request valid
//   i_stall    downstream stall
//   o_decode   one-hot target; bit NS flags "no slave" (bus error)
//   o_addr     registered address
//   o_data     registered payload
// -----------------------------------------------------------------------------
module addrdecode_skid #(
  parameter int                NS           = 4,
  parameter int                AW           = 32,
  parameter int                DW           = 38,
  parameter logic [NS*AW-1:0]  SLAVE_ADDR   = {32'h8000_0000, 32'h0000_0000,
                                               32'h1000_0000, 32'h0000_0000},
  parameter logic [NS*AW-1:0]  SLAVE_MASK   = {32'h8000_0000, 32'hC000_0000,
                                               32'hFF00_0000, 32'hF000_0000},
  parameter bit                OPT_LOWPOWER = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_stall,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic [NS-1:0] i_enable,
  output logic          o_valid,
  input  logic          i_stall,
  output logic [NS:0]   o_decode,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  // Skid entry.
  logic          skid_valid;
  logic [AW-1:0] skid_addr;
  logic [DW-1:0] skid_data;

  // Source presented to the output register: the skid entry first, so
  // ordering is kept, otherwise the input port.
  logic          src_valid;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_data;
  logic [NS-1:0] match;
  logic [NS:0]   src_decode;

  logic load;
  logic skid_fill;

  // The output register is free when empty, or when its content retires
  // this cycle.
  assign load = !o_valid || !i_stall;

  // A new request arrives while the output is held. Park it in the skid
  // entry. The !skid_valid term is what makes i_valid ignored while
  // o_stall is high.
  assign skid_fill = i_valid && !skid_valid && o_valid && i_stall;

  assign src_valid = skid_valid || i_valid;
  assign src_addr  = skid_valid ? skid_addr : i_addr;
  assign src_data  = skid_valid ? skid_data : i_data;

  // o_stall is exactly the skid-full flag, so it is a register output.
  assign o_stall = skid_valid;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    match = '0;
    for (int k = 0; k < NS; k++) begin
      match[k] = i_enable[k]
              && (((src_addr ^ SLAVE_ADDR[k*AW +: AW]) & SLAVE_MASK[k*AW +: AW]) == '0);
    end
  end

  // Priority pick. The loop walks from the highest index down, so the lowest
  // matching slave is written last and wins. With no match, only the
  // bus-error bit remains set.
  always_comb begin
    src_decode = '0;
    if (src_valid) begin
      src_decode[NS] = 1'b1;
      for (int k = NS - 1; k >= 0; k--) begin
        if (match[k]) begin
          src_decode    = '0;
          src_decode[k] = 1'b1;
        end
      end
    end
  end

  // Output register.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: the address and payload registers are reset too, not just the
      // valid flag, so a reset output never shows stale data in any mode.
      o_valid  <= 1'b0;
      o_decode <= '0;
      o_addr   <= '0;
      o_data   <= '0;
    end else if (load) begin
      o_valid  <= src_valid;
      o_decode <= src_decode;
      if (!OPT_LOWPOWER || src_valid) begin
        o_addr <= src_addr;
        o_data <= src_data;
      end else begin
        o_addr <= '0;
        o_data <= '0;
      end
    end
  end

  // Skid register. Fill and load never coincide: a fill needs the output
  // held (o_valid && i_stall), and that blocks a load.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      skid_valid <= 1'b0;
      skid_addr  <= '0;
      skid_data  <= '0;
    end else if (skid_fill) begin
      skid_valid <= 1'b1;
      skid_addr  <= i_addr;
      skid_data  <= i_data;
    end else if (load) begin
      // Draining, or already empty: the entry is free after this edge.
      skid_valid <= 1'b0;
      if (OPT_LOWPOWER) begin
        skid_addr <= '0;
        skid_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_addrdecode_skid.sv
// -----------------------------------------------------------------------------
// tb_addrdecode_skid
//
// Self-checking bench for addrdecode_skid. Two instances share all inputs:
// dut uses OPT_LOWPOWER=0 and dut_lp uses OPT_LOWPOWER=1.
//
// The reference model is transaction-level. It keeps an in-order queue of the
// requests in the block, with at most two entries: the front entry is the one
// on the output, and a second entry means the upstream is stalled. A request's
// decode is computed from the region table when that request reaches the
// front.
// -----------------------------------------------------------------------------
module tb_addrdecode_skid;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 38;

  // Region table, slave 0 first.
  localparam logic [AW-1:0] BASE [NS] = '{32'h0000_0000, 32'h1000_0000,
                                          32'h0000_0000, 32'h8000_0000};
  localparam logic [AW-1:0] MASK [NS] = '{32'hF000_0000, 32'hFF00_0000,
                                          32'hC000_0000, 32'h8000_0000};

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NS:0]   dec;
  } req_t;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_valid = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_data = '0;
  logic [NS-1:0] i_enable = '1;
  logic          i_stall = 1'b0;

  logic          o_stall, o_valid;
  logic [NS:0]   o_decode;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;

  logic          lp_stall, lp_valid;
  logic [NS:0]   lp_decode;
  logic [AW-1:0] lp_addr;
  logic [DW-1:0] lp_data;

  int errors = 0;
  int checks = 0;

  req_t q[$];                       // model: requests inside the block
  logic [AW+DW-1:0] sent[$];        // streaming: accepted, in order
  logic [AW+DW-1:0] emitted[$];     // streaming: retired by the DUT
  bit   sb_on = 1'b0;
  bit   last_accept;

  addrdecode_skid #(.NS(NS), .AW(AW), .DW(DW), .OPT_LOWPOWER(1'b0)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_stall(o_stall),
    .i_addr(i_addr), .i_data(i_data), .i_enable(i_enable), .o_valid(o_valid),
    .i_stall(i_stall), .o_decode(o_decode), .o_addr(o_addr), .o_data(o_data)
  );

  addrdecode_skid #(.NS(NS), .AW(AW), .DW(DW), .OPT_LOWPOWER(1'b1)) dut_lp (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_stall(lp_stall),
    .i_addr(i_addr), .i_data(i_data), .i_enable(i_enable), .o_valid(lp_valid),
    .i_stall(i_stall), .o_decode(lp_decode), .o_addr(lp_addr), .o_data(lp_data)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS:0] ref_decode(input logic [AW-1:0] a, input logic [NS-1:0] en);
    logic [NS:0] r;
    r = '0;
    for (int k = 0; k < NS; k++) begin
      if (en[k] && ((a & MASK[k]) == (BASE[k] & MASK[k]))) begin
        r[k] = 1'b1;
        return r;
      end
    end
    r[NS] = 1'b1;
    return r;
  endfunction

  task automatic model_update();
    bit   was_empty, can_accept, retire;
    req_t r;
    last_accept = 1'b0;
    if (i_reset) begin
      q.delete();
      return;
    end
    was_empty  = (q.size() == 0);
    can_accept = (q.size() < 2);
    retire     = (q.size() > 0) && !i_stall;
    if (retire) void'(q.pop_front());
    if (i_valid && can_accept) begin
      r.addr = i_addr;
      r.data = i_data;
      r.dec  = '0;
      q.push_back(r);
      last_accept = 1'b1;
      if (sb_on) sent.push_back({i_addr, i_data});
    end
    if ((retire || was_empty) && q.size() > 0) begin
      r = q[0];
      r.dec = ref_decode(r.addr, i_enable);
      q[0] = r;
    end
  endtask

  task automatic check_outputs();
    check("valid", 64'(o_valid), 64'(q.size() > 0));
    check("stall", 64'(o_stall), 64'(q.size() == 2));
    check("lp_valid", 64'(lp_valid), 64'(q.size() > 0));
    check("lp_stall", 64'(lp_stall), 64'(q.size() == 2));
    if (q.size() > 0) begin
      check("decode", 64'(o_decode), 64'(q[0].dec));
      check("addr", 64'(o_addr), 64'(q[0].addr));
      check("data", 64'(o_data), 64'(q[0].data));
      check("lp_decode", 64'(lp_decode), 64'(q[0].dec));
      check("lp_addr", 64'(lp_addr), 64'(q[0].addr));
    end else begin
      check("decode_idle", 64'(o_decode), 64'(0));
      check("lp_decode_idle", 64'(lp_decode), 64'(0));
      check("lp_addr_idle", 64'(lp_addr), 64'(0));
      check("lp_data_idle", 64'(lp_data), 64'(0));
    end
  endtask

  // One clock cycle: drive the inputs, advance the model at the edge, then
  // check the outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic st, input logic [NS-1:0] en, input logic rst);
    if (sb_on && o_valid && !st) emitted.push_back({o_addr, o_data});
    i_valid  = v;
    i_addr   = a;
    i_data   = d;
    i_stall  = st;
    i_enable = en;
    i_reset  = rst;
    @(posedge i_clk);
    model_update();
    #1;
    check_outputs();
  endtask

  initial begin
    logic [AW-1:0] prio_addr [5] = '{32'h0000_1000, 32'h1000_0004, 32'h1100_0000,
                                     32'h4000_0000, 32'h9000_0000};
    logic [NS:0]   prio_dec  [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b10000, 5'b01000};
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [63:0]   rnd;
    int            idx, cyc;

    // Reset.
    step(1'b0, '0, '0, 1'b0, 4'hF, 1'b1);
    step(1'b0, '0, '0, 1'b0, 4'hF, 1'b1);
    check("rst_addr", 64'(o_addr), 64'(0));
    check("rst_data", 64'(o_data), 64'(0));

    // Priority and bus-error decode, one request per cycle.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, prio_addr[i], 38'(i + 1), 1'b0, 4'hF, 1'b0);
      check("prio_decode", 64'(o_decode), 64'(prio_dec[i]));
    end

    // Enable mask.
    step(1'b1, 32'h0000_1000, 38'h11, 1'b0, 4'b1110, 1'b0);
    check("en_decode_a", 64'(o_decode), 64'(5'b00100));
    step(1'b1, 32'h9000_0000, 38'h22, 1'b0, 4'b0110, 1'b0);
    check("en_decode_b", 64'(o_decode), 64'(5'b10000));
    step(1'b0, '0, '0, 1'b0, 4'hF, 1'b0);

    // Skid fill and drain.
    step(1'b1, 32'h1000_0000, 38'hA, 1'b0, 4'hF, 1'b0);  // A accepted
    step(1'b1, 32'h8000_0000, 38'hB, 1'b1, 4'hF, 1'b0);  // B into skid
    check("skid_stall", 64'(o_stall), 64'(1));
    check("skid_hold_a", 64'(o_addr), 64'(32'h1000_0000));
    // o_stall must not follow i_stall within a cycle.
    i_stall = 1'b0;
    #1;
    check("stall_no_comb", 64'(o_stall), 64'(1));
    i_stall = 1'b1;
    #1;
    step(1'b0, '0, '0, 1'b1, 4'h0, 1'b0);                // hold; enables off
    check("skid_hold_a2", 64'(o_addr), 64'(32'h1000_0000));
    check("skid_hold_dec", 64'(o_decode), 64'(5'b00010));
    // Release, offering C at the same time: C must be refused.
    step(1'b1, 32'h0000_0040, 38'hC, 1'b0, 4'hF, 1'b0);
    check("drain_b_addr", 64'(o_addr), 64'(32'h8000_0000));
    check("drain_b_dec", 64'(o_decode), 64'(5'b01000));
    check("drain_stall", 64'(o_stall), 64'(0));
    step(1'b0, '0, '0, 1'b0, 4'hF, 1'b0);
    step(1'b0, '0, '0, 1'b0, 4'hF, 1'b0);

    // Streaming: 16 random requests under a random downstream stall.
    sb_on = 1'b1;
    idx = 0;
    cyc = 0;
    rnd = {$urandom(), $urandom()};
    ra = $urandom();
    rd = rnd[DW-1:0];
    while (idx < 16 && cyc < 300) begin
      step(1'b1, ra, rd, 1'($urandom_range(0, 1)), 4'hF, 1'b0);
      cyc++;
      if (last_accept) begin
        idx++;
        rnd = {$urandom(), $urandom()};
        ra = $urandom();
        rd = rnd[DW-1:0];
      end
    end
    check("stream_accepted", 64'(idx), 64'(16));
    cyc = 0;
    while (q.size() > 0 && cyc < 100) begin
      step(1'b0, '0, '0, 1'($urandom_range(0, 1)), 4'hF, 1'b0);
      cyc++;
    end
    step(1'b0, '0, '0, 1'b0, 4'hF, 1'b0);
    sb_on = 1'b0;
    check("stream_emitted", 64'(emitted.size()), 64'(16));
    for (int i = 0; i < 16 && i < emitted.size() && i < sent.size(); i++) begin
      check("stream_order", 64'(emitted[i]), 64'(sent[i]));
    end

    // Low-power idle: one transfer, then idle cycles (checked every step).
    step(1'b1, 32'hC000_1234, 38'h3F_0000_0001, 1'b0, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 4'hF, 1'b0);
    check("lp_idle_addr", 64'(lp_addr), 64'(0));

    // Mid-operation reset with the skid entry full.
    step(1'b1, 32'h1000_0100, 38'h5, 1'b0, 4'hF, 1'b0);
    step(1'b1, 32'h8000_0100, 38'h6, 1'b1, 4'hF, 1'b0);
    check("pre_rst_stall", 64'(o_stall), 64'(1));
    step(1'b1, 32'h0000_0200, 38'h7, 1'b1, 4'hF, 1'b1);
    check("mid_rst_addr", 64'(o_addr), 64'(0));
    check("mid_rst_data", 64'(o_data), 64'(0));
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 4'hF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addrdecode_skid.md
# addrdecode_skid

Registered, fully-buffered address decoder for the crossbar request path. Accepts a request (address + payload), picks exactly one of NS slaves (lowest index wins on overlapping regions, with a run-time per-slave enable), and presents the request with a one-hot decode one cycle later. An internal skid register makes o_stall a registered signal, so no combinational path runs from downstream i_stall to upstream o_stall. Unmapped or disabled targets decode to the bus-error index NS.

## Interface

- NS, 4: number of slaves.
- AW, 32: address width.
- DW, 38: payload width.
- SLAVE_ADDR, {32'h8000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000}: NS×AW base addresses; slave k at [k*AW +: AW].
- SLAVE_MASK, {32'h8000_0000, 32'hC000_0000, 32'hFF00_0000, 32'hF000_0000}: NS×AW compare masks; mask 0 matches everything.
- OPT_LOWPOWER, 0: when 1, o_addr/o_data/o_decode are forced to 0 whenever o_valid is 0, and the skid register is cleared when empty.
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream request valid.
- o_stall  out  1  upstream stall; registered.
- i_addr  in  AW  request address.
- i_data  in  DW  request payload, passed through untouched.
- i_enable  in  NS  per-slave enable; a disabled slave never matches.
- o_valid  out  1  downstream request valid.
- i_stall  in  1  downstream stall.
- o_decode  out  NS+1  one-hot target; bit NS = no slave selected (bus error).
- o_addr  out  AW  registered address.
- o_data  out  DW  registered payload.

## Operation

- Match: slave k matches when ((addr ^ SLAVE_ADDR[k]) & SLAVE_MASK[k]) == 0 and i_enable[k] == 1.
- Priority: the lowest matching k sets o_decode[k]; no other bit is set. No match sets o_decode[NS] alone. o_valid == (o_decode != 0) always holds.
- Datapath: upstream → skid register (1 entry: valid, addr, data) → decode → output register (o_valid, o_decode, o_addr, o_data).
- Source mux: the output register loads from the skid entry if it is valid, else from the input port.
- Load condition: load when !o_valid || !i_stall. Loading when the source is invalid clears o_valid and o_decode.
- Skid fill: if i_valid && !o_stall && o_valid && i_stall, capture the input into the skid register and set o_stall.
- Skid drain: when the output register loads from the skid entry, clear the skid register and o_stall. i_valid is ignored while o_stall is 1.
- Enable sampling: i_enable is sampled in the cycle the output register loads. A held output keeps its decode even if i_enable changes later.
- Hold: while o_valid && i_stall, o_valid, o_decode, o_addr and o_data are stable.

## Timing

- Reset: o_valid=0, o_stall=0, o_decode=0, skid register empty. o_addr=0 and o_data=0 on reset in all modes.
- Reset wins over every other event. A request in flight or held in the skid register at reset is dropped.
- Latency: i_valid && !o_stall at cycle N gives o_valid at N+1, if the output register was free or draining at N.
- Throughput: 1 request/cycle with i_stall=0; no bubbles.
- Stall boundary: the first cycle of a downstream stall with a new input fills the skid register. o_stall rises at N+1, and the request accepted at N is not lost.
- Stall release: with the skid full and i_stall dropping at cycle M, the held output retires at M. The skid entry appears at M+1, and o_stall=0 at M+1.
- Simultaneous release and new input: the input is not accepted in a cycle where o_stall=1, even if i_stall=0 in that cycle.
- Ordering: strict in-order; the skid entry always precedes any later input.

## Test plan

- Priority/error decode (all enables 1, i_stall=0), addresses one per cycle: 0x0000_1000, 0x1000_0004, 0x1100_0000, 0x4000_0000, 0x9000_0000. Required o_decode, one cycle later each: 5'b00001, 5'b00010, 5'b00100, 5'b10000, 5'b01000.
- Enable mask: i_enable=4'b1110, addr 0x0000_1000 → o_decode=5'b00100. i_enable=4'b0110, addr 0x9000_0000 → o_decode=5'b10000.
- Skid fill/drain: send A=0x1000_0000 and B=0x8000_0000 back-to-back while holding i_stall=1 from the cycle A becomes valid. Required: o_stall=1 the cycle after B is accepted, and A held stable. Release i_stall: A retires, B is on the output the next cycle with o_decode=5'b01000, then o_stall=0.
- Streaming: 16 consecutive requests with a random i_stall pattern. Every request is emitted exactly once, in order, with o_addr/o_data matching and o_stall never combinationally dependent on i_stall.
- Mid-operation reset: with the skid full and o_valid=1, assert i_reset for one cycle. Next cycle: o_valid=0, o_stall=0, o_decode=0, o_addr=0, o_data=0, and no stale request appears afterwards.
- OPT_LOWPOWER=1: idle cycles after a transfer give o_addr=0, o_data=0, o_decode=0 while o_valid=0.
